crop_window_stream: RTL

- Upstream feeder for the Gaussian/CNN chain.
- Accepts a full raster-order frame (IN_ROWS x IN_COLS) on an AXI-Stream input.
- Forwards only the OUT_ROWS x OUT_COLS window whose top-left corner is at (Y_1, X_1), unmodified and in raster order, on an AXI-Stream output; all other pixels are consumed and dropped.
- Frame-level control uses the ap_start/ap_done/ap_idle/ap_ready block protocol so it drops in wherever the cropped stream is consumed.

---
 rtl/crop_window_stream.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/crop_window_stream.sv
// Crops a fixed OUT_ROWS x OUT_COLS window at (Y_1, X_1) out of a raster frame and drops all other pixels.
// Latency: one cycle from an in-window input handshake to crop_output_TVALID; 1 pixel/cycle sustained.
// Backpressure: a full output register stalls only in-window input pixels; out-of-window pixels always drain.
module crop_window_stream #(
  parameter int PIXEL_BIT_WIDTH = 16,
  parameter int IN_ROWS         = 100,
  parameter int IN_COLS         = 160,
  parameter int OUT_ROWS        = 48,
  parameter int OUT_COLS        = 48,
  parameter int Y_1             = 10,
  parameter int X_1             = 10
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       ap_start,
  output logic                       ap_done,
  output logic                       ap_idle,
  output logic                       ap_ready,
  input  logic [PIXEL_BIT_WIDTH-1:0] crop_input_TDATA,
  input  logic                       crop_input_TVALID,
  output logic                       crop_input_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0] crop_output_TDATA,
  output logic                       crop_output_TVALID,
  input  logic                       crop_output_TREADY
);

  localparam int RW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
  localparam int CW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;

  // Window bounds are kept inclusive so every constant fits the counter width,
  // even when the window touches the last row or column of the frame.
  localparam logic [RW-1:0] ROW_FIRST = RW'(Y_1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(Y_1 + OUT_ROWS - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IN_ROWS - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(X_1);
  localparam logic [CW-1:0] COL_LAST  = CW'(X_1 + OUT_COLS - 1);
  localparam logic [CW-1:0] COL_MAX   = CW'(IN_COLS - 1);

  // A window that runs off the frame can never be produced; refuse to build it.
  if ((Y_1 + OUT_ROWS > IN_ROWS) || (X_1 + OUT_COLS > IN_COLS)) begin : g_bad_window
    $error("crop_window_stream: crop window exceeds the input frame");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     state;
  logic [RW-1:0]              row;
  logic [CW-1:0]              col;
  logic                       out_valid;
  logic [PIXEL_BIT_WIDTH-1:0] out_data;
  logic                       in_window;
  logic                       in_hs;
  logic                       out_hs;
  logic                       last_pix;

  // Position classification of the pixel currently offered on the input.
  always_comb begin
    in_window = (row >= ROW_FIRST) && (row <= ROW_LAST) &&
                (col >= COL_FIRST) && (col <= COL_LAST);
  end

  // Out-of-window pixels never touch the output register, so they are accepted even when it is full.
  assign crop_input_TREADY  = (state == S_RUN) && (!in_window || !out_valid || crop_output_TREADY);
  assign in_hs              = crop_input_TVALID && crop_input_TREADY;
  assign out_hs             = out_valid && crop_output_TREADY;
  assign last_pix           = (row == ROW_MAX) && (col == COL_MAX);
  assign crop_output_TVALID = out_valid;
  assign crop_output_TDATA  = out_data;

  // One-entry output register; a load on the same cycle as a drain keeps it full for full throughput.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_hs && in_window) begin
      out_valid <= 1'b1;
      out_data  <= crop_input_TDATA;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

  // Frame control FSM with raster counters and registered block-protocol outputs.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state    <= S_IDLE;
      row      <= '0;
      col      <= '0;
      ap_done  <= 1'b0;
      ap_ready <= 1'b0;
      ap_idle  <= 1'b1;
    end else begin
      ap_done  <= 1'b0;
      ap_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            state   <= S_RUN;
            row     <= '0;
            col     <= '0;
            ap_idle <= 1'b0;
          end
        end
        S_RUN: begin
          if (in_hs) begin
            if (col == COL_MAX) begin
              col <= '0;
              row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_pix) begin
              state    <= S_DRAIN;
              ap_ready <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // The register is empty, or its final word leaves on this edge.
          if (!out_valid || crop_output_TREADY) begin
            state   <= S_DONE;
            ap_done <= 1'b1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          ap_idle <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          ap_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule
